// File: rtl/mul_pkg.sv
// Shared types and sizing helpers for the sequential shift-add multiplier.
package mul_pkg;

    localparam int MUL_W_DEFAULT   = 16;
    localparam int MUL_BPC_DEFAULT = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Step counter must be able to hold W/BPC, the value it reaches on entering DONE.
    function automatic int step_cnt_width(input int w, input int bpc);
        return $clog2(w / bpc + 1);
    endfunction

endpackage

// File: rtl/seq_multiplier_if.sv
// Operand/result handshake bundle between a producer/consumer and seq_multiplier.
interface seq_multiplier_if
    import mul_pkg::*;
#(
    parameter int W = MUL_W_DEFAULT
) ();

    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   x;
    logic [W-1:0]   y;
    logic           sgn;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] z;

    modport master (
        output in_valid, x, y, sgn, out_ready,
        input  in_ready, out_valid, z
    );

    modport slave (
        input  in_valid, x, y, sgn, out_ready,
        output in_ready, out_valid, z
    );

endinterface

// File: rtl/mul_step.sv
// One shift-add step: adds BPC multiplier bits' worth of partial product into the
// upper half of the accumulator, then shifts the whole accumulator right by BPC.
module mul_step #(
    parameter int W   = 16,
    parameter int BPC = 1
) (
    input  logic [2*W-1:0] acc_in,
    input  logic [W-1:0]   mcand,
    input  logic [BPC-1:0] mbits,
    input  logic           sgn,
    input  logic           last,
    output logic [2*W-1:0] acc_out
);

    localparam int PW = W + BPC + 1;
    localparam int EW = 2 * W + BPC + 1;

    logic signed [PW-1:0] x_ext;
    logic signed [PW-1:0] pp;
    logic signed [EW-1:0] acc_ext;
    logic signed [EW-1:0] pp_ext;
    logic signed [EW-1:0] sum;

    // In signed mode the multiplier MSB carries negative weight, so on the final
    // step that bit subtracts the multiplicand instead of adding it.
    always_comb begin
        x_ext = {{(BPC + 1){sgn & mcand[W-1]}}, mcand};
        pp    = '0;
        for (int i = 0; i < BPC; i++) begin
            if (mbits[i]) begin
                if (sgn && last && (i == BPC - 1)) begin
                    pp = pp - (x_ext <<< i);
                end else begin
                    pp = pp + (x_ext <<< i);
                end
            end
        end
        acc_ext = {{(BPC + 1){sgn & acc_in[2*W-1]}}, acc_in};
        pp_ext  = {{(EW - PW){pp[PW-1]}}, pp};
        sum     = acc_ext + (pp_ext <<< W);
        acc_out = (2 * W)'(sum >>> BPC);
    end

endmodule

// File: rtl/seq_multiplier.sv
// Sequential W x W multiplier retiring BPC multiplier bits per cycle, signed or
// unsigned, with valid/ready handshakes on both operand and result sides.
module seq_multiplier
    import mul_pkg::*;
#(
    parameter int W   = MUL_W_DEFAULT,
    parameter int BPC = MUL_BPC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    seq_multiplier_if.slave bus
);

    localparam int STEPS = W / BPC;
    localparam int CNT_W = step_cnt_width(W, BPC);

    if (W < 4 || W > 64 || (W % 2) != 0 || !(BPC == 1 || BPC == 2 || BPC == 4) ||
        (W % BPC) != 0) begin : g_bad_params
        $error("seq_multiplier: illegal W/BPC combination");
    end

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]     x_q, x_d;
    logic [W-1:0]     y_q, y_d;
    logic             sgn_q, sgn_d;
    logic [2*W-1:0]   acc_q, acc_d;
    logic [2*W-1:0]   acc_step;
    logic             last_step;

    assign last_step = (cnt_q == CNT_W'(STEPS - 1));

    mul_step #(
        .W   (W),
        .BPC (BPC)
    ) u_step (
        .acc_in  (acc_q),
        .mcand   (x_q),
        .mbits   (y_q[BPC-1:0]),
        .sgn     (sgn_q),
        .last    (last_step),
        .acc_out (acc_step)
    );

    // y_q is consumed from the bottom, so it shifts down as bits are retired.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        sgn_d   = sgn_q;
        acc_d   = acc_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    state_d = BUSY;
                    cnt_d   = '0;
                    x_d     = bus.x;
                    y_d     = bus.y;
                    sgn_d   = bus.sgn;
                    acc_d   = '0;
                end
            end
            BUSY: begin
                acc_d = acc_step;
                y_d   = y_q >> BPC;
                cnt_d = cnt_q + 1'b1;
                if (last_step) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            sgn_q   <= 1'b0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            sgn_q   <= sgn_d;
            acc_q   <= acc_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.z         = acc_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier: three builds (BPC=1/2/4) share one stimulus stream.
module tb_seq_multiplier;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    seq_multiplier_if #(.W(16)) if1 ();
    seq_multiplier_if #(.W(16)) if2 ();
    seq_multiplier_if #(.W(16)) if4 ();

    seq_multiplier #(.W(16), .BPC(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
    seq_multiplier #(.W(16), .BPC(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));
    seq_multiplier #(.W(16), .BPC(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input logic v, input logic [15:0] a, input logic [15:0] b,
                                  input logic s);
        if1.in_valid = v; if1.x = a; if1.y = b; if1.sgn = s;
        if2.in_valid = v; if2.x = a; if2.y = b; if2.sgn = s;
        if4.in_valid = v; if4.x = a; if4.y = b; if4.sgn = s;
    endtask

    task automatic set_out_ready(input logic r);
        if1.out_ready = r;
        if2.out_ready = r;
        if4.out_ready = r;
    endtask

    function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b,
                                            input logic s);
        logic [31:0] ea;
        logic [31:0] eb;
        ea = s ? {{16{a[15]}}, a} : {16'h0000, a};
        eb = s ? {{16{b[15]}}, b} : {16'h0000, b};
        return ea * eb;
    endfunction

    // One full transaction on all three builds; hold keeps in_valid high with
    // scrambled operands until after the result handshake.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic s,
                          input logic [31:0] exp, input bit hold, input int stall,
                          input string tag);
        int lat1, lat2, lat4;
        lat1 = -1; lat2 = -1; lat4 = -1;
        @(negedge clk);
        apply_stimulus(1'b1, a, b, s);
        check_output({tag, "_in_ready"}, 64'(if1.in_ready), 64'd1);
        @(posedge clk); #1;
        if (!hold) apply_stimulus(1'b0, a, b, s);
        for (int cyc = 1; cyc <= 40 && lat1 < 0; cyc++) begin
            if (hold) begin
                @(negedge clk);
                apply_stimulus(1'b1, a ^ 16'(cyc * 37), ~b, ~s);
            end
            @(posedge clk); #1;
            if (hold && cyc == 2) check_output({tag, "_busy_in_ready"}, 64'(if1.in_ready), 64'd0);
            if (lat2 < 0 && if2.out_valid === 1'b1) lat2 = cyc;
            if (lat4 < 0 && if4.out_valid === 1'b1) lat4 = cyc;
            if (if1.out_valid === 1'b1) lat1 = cyc;
        end
        check_output({tag, "_lat_bpc1"}, 64'(lat1), 64'd16);
        check_output({tag, "_lat_bpc2"}, 64'(lat2), 64'd8);
        check_output({tag, "_lat_bpc4"}, 64'(lat4), 64'd4);
        check_output({tag, "_z_bpc1"}, 64'(if1.z), 64'(exp));
        check_output({tag, "_z_bpc2"}, 64'(if2.z), 64'(exp));
        check_output({tag, "_z_bpc4"}, 64'(if4.z), 64'(exp));
        for (int k = 0; k < stall; k++) begin
            @(posedge clk); #1;
            check_output({tag, "_stall_hold"}, 64'({if1.out_valid, if1.in_ready, if1.z}),
                         64'({1'b1, 1'b0, exp}));
        end
        @(negedge clk);
        set_out_ready(1'b1);
        @(posedge clk); #1;
        set_out_ready(1'b0);
        check_output({tag, "_after_hs"}, 64'({if1.in_ready, if1.out_valid, if4.in_ready}),
                     64'(3'b101));
        @(negedge clk);
        apply_stimulus(1'b0, a, b, s);
    endtask

    initial begin
        int stray;
        logic [15:0] ra;
        logic [15:0] rb;
        logic rs;
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b1;
        apply_stimulus(1'b0, 16'h0, 16'h0, 1'b0);
        set_out_ready(1'b0);

        #2 rst_n = 1'b0;
        #1;
        check_output("reset_in_ready", 64'(if1.in_ready), 64'd1);
        check_output("reset_out_valid", 64'(if1.out_valid), 64'd0);
        check_output("reset_z", 64'(if1.z), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_op(16'hDEAD, 16'hBEEF, 1'b0, 32'hA614_4983, 1'b0, 0, "u_dead_beef");
        run_op(16'hDEAD, 16'hBEEF, 1'b1, 32'h0878_4983, 1'b0, 0, "s_dead_beef");
        run_op(16'h8000, 16'h8000, 1'b1, 32'h4000_0000, 1'b0, 0, "s_min_min");
        run_op(16'hFFFF, 16'h0005, 1'b1, 32'hFFFF_FFFB, 1'b0, 0, "s_neg1_x5");
        run_op(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001, 1'b0, 10, "u_max_stall");
        run_op(16'h0000, 16'h0000, 1'b0, 32'h0000_0000, 1'b0, 0, "u_zero");
        run_op(16'h8000, 16'h0001, 1'b0, 32'h0000_8000, 1'b0, 0, "u_msb_x1");
        run_op(16'h0100, 16'h0003, 1'b0, 32'h0000_0300, 1'b1, 0, "hold_valid");

        @(negedge clk);
        apply_stimulus(1'b1, 16'h1234, 16'h5678, 1'b0);
        @(posedge clk); #1;
        apply_stimulus(1'b0, 16'h1234, 16'h5678, 1'b0);
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_output("midreset_out_valid",
                     64'({if1.out_valid, if2.out_valid, if4.out_valid}), 64'd0);
        check_output("midreset_z", 64'(if1.z), 64'd0);
        check_output("midreset_in_ready", 64'(if1.in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        stray = 0;
        repeat (20) begin
            @(posedge clk); #1;
            stray += int'(if1.out_valid | if2.out_valid | if4.out_valid);
        end
        check_output("midreset_no_stray_valid", 64'(stray), 64'd0);
        run_op(16'd3, 16'd7, 1'b0, 32'd21, 1'b0, 0, "after_reset_3x7");

        for (int i = 0; i < 100; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rs = 1'(i % 2);
            run_op(ra, rb, rs, ref_mul(ra, rb, rs), 1'b0, 0, "random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
